fetch_unit: RTL and testbench

Instruction fetch stage of the 8-bit NRISC core. Holds the program counter, issues one request at a time to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC to decode over a valid/ready handshake. Branch redirects squash wrong-path fetches. The next-PC choice between PC+1 and the branch target is made by an 8-bit 2:1 mux.

---
 rtl/nrisc_pkg.sv | 15 +
 rtl/fetch_unit_mux21.sv | 13 +
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// Shared definitions for the 8-bit NRISC core: datapath width, fetch FSM
// states and the default reset program counter.
package nrisc_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

endpackage : nrisc_pkg

// File: rtl/fetch_unit_mux21.sv
// Plain 2:1 multiplexer used to choose the next program counter.
module mux21 #(
  parameter int W = 8
) (
  input  logic [W-1:0] in1_i,
  input  logic [W-1:0] in2_i,
  input  logic         sel_i,
  output logic [W-1:0] out_o
);

  assign out_o = sel_i ? in2_i : in1_i;

endmodule : mux21

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs one req/ack transaction at a
// time against instruction memory and hands each fetched word to decode
// over valid/ready. Branch redirects squash wrong-path work; a redirect
// that lands during an outstanding fetch is remembered until the ack.
module fetch_unit
  import nrisc_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [DATA_W-1:0] branch_target
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] instr_pc_q, instr_pc_d;
  logic              redir_pend_q, redir_pend_d;
  logic [DATA_W-1:0] redir_pc_q, redir_pc_d;

  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W-1:0] redir_addr;
  logic              redir_take;
  logic [DATA_W-1:0] pc_next;

  // A live strobe beats a remembered redirect, so the last target wins.
  assign pc_inc     = pc_q + 8'd1;
  assign redir_take = branch_en | redir_pend_q;
  assign redir_addr = branch_en ? branch_target : redir_pc_q;

  mux21 #(.W(DATA_W)) u_next_pc_mux (
    .in1_i (pc_inc),
    .in2_i (redir_addr),
    .sel_i (redir_take),
    .out_o (pc_next)
  );

  // Next-state and register-update logic for the fetch FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (branch_en) pc_d = pc_next;
      end
      FETCH: begin
        if (mem_ack) begin
          if (redir_take) begin
            // Wrong-path data: drop it and refetch at the redirect address.
            pc_d         = pc_next;
            redir_pend_d = 1'b0;
          end else begin
            state_d    = VALID;
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
          end
        end else if (branch_en) begin
          // The memory handshake is never aborted; remember the redirect.
          redir_pend_d = 1'b1;
          redir_pc_d   = branch_target;
        end
      end
      VALID: begin
        // Either a transfer (pc+1) or a branch squash (target) ends VALID.
        if (branch_en || instr_ready) begin
          state_d = FETCH;
          pc_d    = pc_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  // All outputs come straight from registers (Moore).
  assign mem_req     = (state_q == FETCH);
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized phase, all cross-checked by a program-order reference model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       branch_en = 1'b0;
  logic [7:0] branch_target = 8'h00;

  // Second instance with a non-zero reset PC to exercise wrap-around.
  logic       w_req;
  logic [7:0] w_addr;
  logic [7:0] w_rdata;
  logic [7:0] w_instr;
  logic [7:0] w_pc;
  logic       w_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory image: word at address a is a ^ 8'hA5.
  assign mem_rdata = mem_addr ^ 8'hA5;
  assign w_rdata   = w_addr ^ 8'hA5;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_en     (branch_en),
    .branch_target (branch_target)
  );

  fetch_unit #(.RESET_PC(8'hFE)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (w_req),
    .mem_addr      (w_addr),
    .mem_ack       (1'b1),
    .mem_rdata     (w_rdata),
    .instr         (w_instr),
    .instr_pc      (w_pc),
    .instr_valid   (w_valid),
    .instr_ready   (1'b1),
    .branch_en     (1'b0),
    .branch_target (8'h00)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    total++;
    assert (obs === expd) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Reference model: tracks the PC whose instruction decode should receive
  // next. Fetches start at that PC, addresses hold until ack, each transfer
  // must deliver (pc, mem[pc]) then pc+1, and any branch makes the target
  // the next expected PC (everything in flight is discarded).
  logic       mon_en = 1'b0;
  logic       in_req;
  logic [7:0] exp_pc;
  logic [7:0] req_addr;
  logic       prev_hold;
  logic [7:0] prev_instr;
  logic [7:0] prev_pc;
  int         xfers = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_req    = 1'b0;
      exp_pc    = 8'h00;
      prev_hold = 1'b0;
    end else if (mon_en) begin
      check("req_valid_exclusive", 32'(mem_req & instr_valid), 0);
      if (mem_req) begin
        if (!in_req) begin
          in_req   = 1'b1;
          req_addr = mem_addr;
          check("req_start_addr", mem_addr, exp_pc);
        end else begin
          check("req_addr_stable", mem_addr, req_addr);
        end
        if (mem_ack) in_req = 1'b0;
      end
      if (prev_hold) begin
        check("stall_valid", instr_valid, 1);
        check("stall_instr", instr, prev_instr);
        check("stall_pc", instr_pc, prev_pc);
      end
      if (instr_valid && instr_ready && !branch_en) begin
        check("xfer_pc", instr_pc, exp_pc);
        check("xfer_instr", instr, exp_pc ^ 8'hA5);
        exp_pc = exp_pc + 8'd1;
        xfers++;
      end
      prev_hold  = instr_valid && !instr_ready && !branch_en;
      prev_instr = instr;
      prev_pc    = instr_pc;
      if (branch_en) exp_pc = branch_target;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  task automatic go_valid(input logic [7:0] pc);
    logic found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (instr_valid && instr_pc == pc) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_valid_pc", found, 1);
  endtask

  initial begin
    logic [7:0] ea;
    logic       found;

    // Reset values while rst_n is low.
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 8'h00);
    check("rst_instr_pc", instr_pc, 8'h00);
    check("rst_wrap_addr", w_addr, 8'hFE);

    // Sequential fetch with always-ready memory and decode.
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    check("idle_no_req", mem_req, 0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        mem_ack = 1'b0;
        instr_ready = 1'b0;
      end
      @(negedge clk);
      check("seq_req", mem_req, 32'(i % 2));
      check("seq_valid", instr_valid, 32'(1 - (i % 2)));
      if (i % 2 == 1) begin
        check("seq_addr", mem_addr, 8'((i - 1) / 2));
        ea = 8'hFE + 8'((i - 1) / 2);
        check("wrap_addr", w_addr, ea);
      end else begin
        check("seq_instr_pc", instr_pc, 8'(i / 2 - 1));
        check("seq_instr", instr, 8'(i / 2 - 1) ^ 8'hA5);
        ea = 8'hFE + 8'(i / 2 - 1);
        check("wrap_instr_pc", w_pc, ea);
        check("wrap_instr", w_instr, ea ^ 8'hA5);
      end
    end

    // Slow memory: ack arrives after three waiting cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) mem_ack = 1'b1;
      @(negedge clk);
      check("slow_req", mem_req, 1);
      check("slow_addr", mem_addr, 8'h02);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("slow_valid", instr_valid, 1);
    check("slow_instr_pc", instr_pc, 8'h02);
    check("slow_instr", instr, 8'hA7);

    // Stalled decode: everything holds and no new request goes out.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_hold_valid", instr_valid, 1);
      check("stall_hold_instr", instr, 8'hA7);
      check("stall_no_req", mem_req, 0);
    end
    @(posedge clk); #1;
    instr_ready = 1'b1; mem_ack = 1'b1;

    // Branch while holding instr_pc=04 with ready high.
    go_valid(8'h04);
    branch_en = 1'b1; branch_target = 8'h40;
    @(posedge clk); #1;
    branch_en = 1'b0;
    @(negedge clk);
    check("brv_valid_drop", instr_valid, 0);
    check("brv_req", mem_req, 1);
    check("brv_addr", mem_addr, 8'h40);
    @(posedge clk); #1;
    branch_en = 1'b1; branch_target = 8'h07; instr_ready = 1'b0;
    @(negedge clk);
    check("brv_next_pc", instr_pc, 8'h40);
    check("brv_next_instr", instr, 8'hE5);

    // Branch two cycles before the ack of an outstanding fetch at 07.
    @(posedge clk); #1;
    branch_en = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("brf_addr0", mem_addr, 8'h07);
    @(posedge clk); #1;
    branch_en = 1'b1; branch_target = 8'h20;
    @(negedge clk);
    check("brf_addr1", mem_addr, 8'h07);
    @(posedge clk); #1;
    branch_en = 1'b0;
    @(negedge clk);
    check("brf_addr2", mem_addr, 8'h07);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(negedge clk);
    check("brf_req_at_ack", mem_req, 1);
    check("brf_addr_at_ack", mem_addr, 8'h07);

    // Same-cycle branch and ack at 20 -> straight to 33.
    @(posedge clk); #1;
    branch_en = 1'b1; branch_target = 8'h33;
    @(negedge clk);
    check("brf_discard_valid", instr_valid, 0);
    check("brf_redirect_addr", mem_addr, 8'h20);
    @(posedge clk); #1;
    branch_en = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("same_valid", instr_valid, 0);
    check("same_addr", mem_addr, 8'h33);

    // Back-to-back pulses 30 then 50 during one fetch: last one wins.
    @(posedge clk); #1;
    branch_en = 1'b1; branch_target = 8'h30;
    @(posedge clk); #1;
    branch_target = 8'h50;
    @(posedge clk); #1;
    branch_en = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    check("b2b_hold_addr", mem_addr, 8'h33);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_req", mem_req, 1);
    check("b2b_addr", mem_addr, 8'h50);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    @(negedge clk);
    check("b2b_instr_pc", instr_pc, 8'h50);
    check("b2b_instr", instr, 8'hF5);

    // Randomized traffic, checked by the reference model.
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      mem_ack       = 1'($urandom_range(0, 1));
      instr_ready   = ($urandom_range(0, 9) < 7);
      branch_en     = ($urandom_range(0, 9) == 0);
      branch_target = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    branch_en = 1'b0; mem_ack = 1'b0;
    check("random_progress", 32'(xfers > 50), 1);

    // Reset in the middle of an outstanding fetch.
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (mem_req) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid_found_req", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_valid", instr_valid, 0);
    check("rst_mid_addr", mem_addr, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("restart_req", mem_req, 1);
    check("restart_addr", mem_addr, 8'h00);

    // Branch in IDLE overrides the reset PC.
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; branch_en = 1'b1; branch_target = 8'h77;
    @(posedge clk); #1;
    branch_en = 1'b0;
    @(negedge clk);
    check("idle_branch_req", mem_req, 1);
    check("idle_branch_addr", mem_addr, 8'h77);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_branch_pc", instr_pc, 8'h77);
    check("idle_branch_instr", instr, 8'h77 ^ 8'hA5);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_unit
